sequential_shifter_16_bit: RTL and testbench

- Multi-cycle, area-lean counterpart to the single-cycle 16-bit barrel shifter.
- Implements the same eight shift/rotate modes with the same mode encodings and carry semantics, one bit position per clock.
- Uses a Start/Busy/Done handshake.
- Drop-in for datapaths that trade latency for area; results must match the barrel shifter bit-for-bit for identical inputs.

---
 rtl/sequential_shifter_16_bit.sv | 149 ++++++++++++++
 tb/tb_sequential_shifter_16_bit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sequential_shifter_16_bit.sv
// rtl/sequential_shifter_16_bit.sv - multi-cycle shifter/rotator, one bit position per enabled clock
module sequential_shifter_16_bit #(
    parameter int DATA_WIDTH   = 16,
    parameter int LENGTH_WIDTH = 4
) (
    input  logic                    Clock_In,
    input  logic                    Reset_n_In,
    input  logic                    Enable_In,
    input  logic                    Start_In,
    input  logic [2:0]              Shifter_Mode_In,
    input  logic [LENGTH_WIDTH-1:0] Shift_Bits_Length_In,
    input  logic                    Carry_In,
    input  logic [DATA_WIDTH-1:0]   Data_In,
    output logic [DATA_WIDTH-1:0]   Shifted_Data_Out,
    output logic                    Carry_Out,
    output logic                    Busy_Out,
    output logic                    Done_Out
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    localparam logic [2:0] M_LSL = 3'd0, M_LSR = 3'd1, M_ASL = 3'd2, M_ASR = 3'd3;
    localparam logic [2:0] M_ROL = 3'd4, M_ROR = 3'd5, M_RCL = 3'd6, M_RCR = 3'd7;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   work_q, work_d;
    logic                    carry_q, carry_d;
    logic [LENGTH_WIDTH-1:0] count_q, count_d;
    logic [2:0]              mode_q, mode_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    carry_out_q, carry_out_d;
    logic                    done_q, done_d;

    logic [DATA_WIDTH-1:0]   step_work;
    logic                    step_carry;

    // One-bit step of the latched mode applied to the work register and carry.
    always_comb begin
        step_work  = work_q;
        step_carry = carry_q;
        case (mode_q)
            M_LSL, M_ASL: begin
                step_carry = work_q[DATA_WIDTH-1];
                step_work  = {work_q[DATA_WIDTH-2:0], 1'b0};
            end
            M_LSR: begin
                step_carry = work_q[0];
                step_work  = {1'b0, work_q[DATA_WIDTH-1:1]};
            end
            M_ASR: begin
                step_carry = work_q[0];
                step_work  = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
            end
            M_ROL: begin
                step_carry = work_q[DATA_WIDTH-1];
                step_work  = {work_q[DATA_WIDTH-2:0], work_q[DATA_WIDTH-1]};
            end
            M_ROR: begin
                step_carry = work_q[0];
                step_work  = {work_q[0], work_q[DATA_WIDTH-1:1]};
            end
            M_RCL: begin
                step_carry = work_q[DATA_WIDTH-1];
                step_work  = {work_q[DATA_WIDTH-2:0], carry_q};
            end
            M_RCR: begin
                step_carry = work_q[0];
                step_work  = {carry_q, work_q[DATA_WIDTH-1:1]};
            end
            default: begin
                step_work  = work_q;
                step_carry = carry_q;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        carry_d     = carry_q;
        count_d     = count_q;
        mode_d      = mode_q;
        data_out_d  = data_out_q;
        carry_out_d = carry_out_q;
        done_d      = done_q;
        if (Enable_In) begin
            case (state_q)
                ST_IDLE: begin
                    done_d = 1'b0;
                    if (Start_In) begin
                        work_d  = Data_In;
                        carry_d = Carry_In;
                        count_d = Shift_Bits_Length_In;
                        mode_d  = Shifter_Mode_In;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (count_q != '0) begin
                        work_d  = step_work;
                        carry_d = step_carry;
                        count_d = count_q - LENGTH_WIDTH'(1);
                    end else begin
                        data_out_d  = work_q;
                        carry_out_d = carry_q;
                        done_d      = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            mode_q      <= '0;
            data_out_q  <= '0;
            carry_out_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            data_out_q  <= data_out_d;
            carry_out_q <= carry_out_d;
            done_q      <= done_d;
        end
    end

    assign Shifted_Data_Out = data_out_q;
    assign Carry_Out        = carry_out_q;
    assign Done_Out         = done_q;
    assign Busy_Out         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sequential_shifter_16_bit.sv
// tb/tb_sequential_shifter_16_bit.sv - directed and random self-checking bench for sequential_shifter_16_bit
module tb_sequential_shifter_16_bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        start;
    logic [2:0]  mode_in;
    logic [3:0]  len_in;
    logic        cin;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        cout;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    bit seen_done;
    logic [15:0] prev_out;
    logic        prev_cout;
    logic [16:0] exp_res;

    always #5 clk = ~clk;

    sequential_shifter_16_bit #(.DATA_WIDTH(16), .LENGTH_WIDTH(4)) dut (
        .Clock_In             (clk),
        .Reset_n_In           (rst_n),
        .Enable_In            (enable),
        .Start_In             (start),
        .Shifter_Mode_In      (mode_in),
        .Shift_Bits_Length_In (len_in),
        .Carry_In             (cin),
        .Data_In              (data_in),
        .Shifted_Data_Out     (data_out),
        .Carry_Out            (cout),
        .Busy_Out             (busy),
        .Done_Out             (done)
    );

    // Closed-form reference: returns {carry, result}.
    function automatic logic [16:0] ref_shift(input logic [2:0] m, input int n,
                                              input logic c, input logic [15:0] d);
        logic [31:0] t;
        logic signed [31:0] ts;
        logic [33:0] t34;
        logic [16:0] x;
        if (n == 0) return {c, d};
        x = {c, d};
        case (m)
            3'd0, 3'd2: begin t = {16'h0, d} << n; return {t[16], t[15:0]}; end
            3'd1: begin t = {d, 16'h0} >> n; return {t[15], t[31:16]}; end
            3'd3: begin ts = $signed({d, 16'h0}) >>> n; return {ts[15], ts[31:16]}; end
            3'd4: begin t = {d, d} << n; return {t[16], t[31:16]}; end
            3'd5: begin t = {d, d} >> n; return {t[15], t[15:0]}; end
            3'd6: begin t34 = {x, x} << n; return t34[33:17]; end
            default: begin t34 = {x, x} >> n; return t34[16:0]; end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // restart_at/stall_at are edge indices after the start edge; -1 / 0 disable them.
    task automatic run_op(input string tag, input logic [2:0] m, input logic [3:0] n,
                          input logic c, input logic [15:0] d,
                          input int restart_at, input int stall_at, input int stall_len);
        @(negedge clk);
        enable = 1'b1; start = 1'b1; mode_in = m; len_in = n; cin = c; data_in = d;
        exp_res = ref_shift(m, int'(n), c, d);
        @(negedge clk);
        start = 1'b0; data_in = ~d; mode_in = m + 3'd1; cin = ~c; len_in = n ^ 4'h5;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            chk({tag, "_hold"}, {15'h0, cout, data_out}, {15'h0, prev_cout, prev_out});
            start  = (cyc == restart_at);
            enable = !(cyc >= stall_at && cyc < stall_at + stall_len);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; enable = 1'b1;
        chk({tag, "_latency"}, 32'(cyc), 32'(int'(n) + 1 + stall_len));
        chk({tag, "_data"}, 32'(data_out), 32'(exp_res[15:0]));
        chk({tag, "_carry"}, 32'(cout), 32'(exp_res[16]));
        prev_out = exp_res[15:0]; prev_cout = exp_res[16];
        @(negedge clk);
        chk({tag, "_idle"}, {30'h0, busy, done}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; start = 1'b0; mode_in = 3'd0;
        len_in = 4'd0; cin = 1'b0; data_in = 16'h0;
        prev_out = 16'h0; prev_cout = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {14'h0, busy, done, data_out}, 32'd0);
        chk("reset_carry", 32'(cout), 32'd0);
        rst_n = 1'b1;

        run_op("lsl_8001_n1", 3'd0, 4'd1,  1'b0, 16'h8001, -1, 0, 0);
        chk("lsl_const_out", {15'h0, cout, data_out}, 32'h1_0002);
        run_op("asr_8010_n4", 3'd3, 4'd4,  1'b0, 16'h8010, -1, 0, 0);
        chk("asr_const_out", {15'h0, cout, data_out}, 32'h0_F801);
        run_op("lsr_8010_n4", 3'd1, 4'd4,  1'b0, 16'h8010, -1, 0, 0);
        chk("lsr_const_out", {15'h0, cout, data_out}, 32'h0_0801);
        run_op("ror_0001_n1", 3'd5, 4'd1,  1'b0, 16'h0001, -1, 0, 0);
        chk("ror_const_out", {15'h0, cout, data_out}, 32'h1_8000);
        run_op("rcl_8000_n2", 3'd6, 4'd2,  1'b0, 16'h8000, -1, 0, 0);
        chk("rcl_const_out", {15'h0, cout, data_out}, 32'h0_0001);
        run_op("rcr_0001_n1", 3'd7, 4'd1,  1'b1, 16'h0001, -1, 0, 0);
        chk("rcr_const_out", {15'h0, cout, data_out}, 32'h1_8000);
        run_op("n0_a5a5",     3'd3, 4'd0,  1'b1, 16'hA5A5, -1, 0, 0);
        chk("n0_const_out", {15'h0, cout, data_out}, 32'h1_A5A5);
        run_op("rol_restart", 3'd4, 4'd15, 1'b1, 16'h1234, 5, 0, 0);
        chk("rol_const_out", {15'h0, cout, data_out}, 32'h0_091A);
        run_op("rol_stall",   3'd4, 4'd15, 1'b0, 16'h1234, -1, 6, 3);
        chk("rol_stall_out", {15'h0, cout, data_out}, 32'h0_091A);
        run_op("asl_ffff_n15", 3'd2, 4'd15, 1'b0, 16'hFFFF, -1, 0, 0);
        chk("asl_const_out", {15'h0, cout, data_out}, 32'h1_8000);

        // Reset mid-shift aborts immediately and never produces a Done.
        @(negedge clk);
        start = 1'b1; mode_in = 3'd4; len_in = 4'd15; cin = 1'b0; data_in = 16'h5A5A;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_outs", {14'h0, busy, done, data_out}, 32'd0);
        chk("mid_reset_carry", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        chk("post_reset_quiet", 32'(seen_done), 32'd0);
        prev_out = 16'h0; prev_cout = 1'b0;

        for (int i = 0; i < 40; i++) begin
            run_op("rand", 3'($urandom_range(7)), 4'($urandom_range(15)),
                   1'($urandom_range(1)), 16'($urandom), -1, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
